// File: rtl/game_pkg.sv
// Shared types and key codes for the 1A2B guessing game.
// Contents: 4-bit digit type (also used by the display side), keypad codes,
//           and the entry-stage state enum.
package game_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t KEY_BKSP  = 4'hA;
  localparam digit_t KEY_ENTER = 4'hB;
  localparam digit_t KEY_CLEAR = 4'hC;

  typedef enum logic [2:0] {
    EMPTY,
    PARTIAL,
    FULL,
    COMMIT,
    HOLD
  } entry_state_t;

  function automatic logic is_digit(input digit_t code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/guess_entry_key_edge.sv
// Keypad press detector: turns the level-style key valid into a one-cycle
// press indication and presents the code to be captured on that edge.
// Ports: clk, reset (sync, active-low), key_valid/key_code in; press/code out.
module key_edge
  import game_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   key_valid,
  input  digit_t key_code,
  output logic   press,
  output digit_t code
);

  // Reset value of 1 means a key already held when reset lifts is not a press.
  logic prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev <= 1'b1;
    end else begin
      prev <= key_valid;
    end
  end

  // Combinational so the entry FSM acts on the same edge that sees the high
  // sample; the consumer registers everything it derives from these.
  assign press = key_valid & ~prev;
  assign code  = key_code;

endmodule

// File: rtl/guess_entry.sv
// Keypad entry stage: buffers three distinct digits, commits them on ENTER
// with a one-cycle ready strobe, then ignores keys for a holdoff window.
// Ports: clk, reset (sync, active-low), iKeyCode/iKeyValid in; committed
//        guess oNum1..3/oNumRdy, echo oEntry1..3/oCount, oGuessCnt, oErr, oBusy.
module guess_entry
  import game_pkg::*;
#(
  parameter int HOLDOFF = 16,
  parameter int MAX_CNT = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] iKeyCode,
  input  logic       iKeyValid,
  output logic [3:0] oNum1,
  output logic [3:0] oNum2,
  output logic [3:0] oNum3,
  output logic       oNumRdy,
  output logic [3:0] oEntry1,
  output logic [3:0] oEntry2,
  output logic [3:0] oEntry3,
  output logic [1:0] oCount,
  output logic [6:0] oGuessCnt,
  output logic       oErr,
  output logic       oBusy
);

  localparam int HW = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
  localparam logic [6:0]    GC_MAX    = 7'(MAX_CNT);

  logic   press;
  digit_t code;

  key_edge u_key_edge (
    .clk       (clk),
    .reset     (reset),
    .key_valid (iKeyValid),
    .key_code  (iKeyCode),
    .press     (press),
    .code      (code)
  );

  entry_state_t state, state_nxt, eff_state;
  logic [HW-1:0] hold_cnt, hold_nxt;
  digit_t        e1_nxt, e2_nxt, e3_nxt;
  logic [1:0]    cnt_nxt;
  logic [6:0]    gc_nxt;
  logic          err_nxt, rdy_nxt, num_ld, busy_nxt;
  logic          dup;

  // Only occupied slots take part in the duplicate check; empty slots read 0,
  // which is itself a legal digit.
  assign dup = ((oCount >= 2'd1) && (oEntry1 == code)) ||
               ((oCount >= 2'd2) && (oEntry2 == code)) ||
               ((oCount == 2'd3) && (oEntry3 == code));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    e1_nxt    = oEntry1;
    e2_nxt    = oEntry2;
    e3_nxt    = oEntry3;
    cnt_nxt   = oCount;
    gc_nxt    = oGuessCnt;
    err_nxt   = 1'b0;
    rdy_nxt   = 1'b0;
    num_ld    = 1'b0;

    // The last HOLD cycle behaves as EMPTY (buffer already cleared), so a
    // press landing on the edge that ends the holdoff is accepted.
    eff_state = state;
    if (state == HOLD && hold_cnt == '0) begin
      eff_state = EMPTY;
      state_nxt = EMPTY;
    end

    case (eff_state)
      EMPTY, PARTIAL, FULL: begin
        if (press) begin
          if (is_digit(code)) begin
            if (eff_state == FULL || dup) begin
              err_nxt = 1'b1;
            end else begin
              case (oCount)
                2'd0:    e1_nxt = code;
                2'd1:    e2_nxt = code;
                default: e3_nxt = code;
              endcase
              cnt_nxt   = oCount + 2'd1;
              state_nxt = (oCount == 2'd2) ? FULL : PARTIAL;
            end
          end else if (code == KEY_BKSP) begin
            if (eff_state == EMPTY) begin
              err_nxt = 1'b1;
            end else begin
              case (oCount)
                2'd1:    e1_nxt = '0;
                2'd2:    e2_nxt = '0;
                default: e3_nxt = '0;
              endcase
              cnt_nxt   = oCount - 2'd1;
              state_nxt = (oCount == 2'd1) ? EMPTY : PARTIAL;
            end
          end else if (code == KEY_CLEAR) begin
            e1_nxt    = '0;
            e2_nxt    = '0;
            e3_nxt    = '0;
            cnt_nxt   = 2'd0;
            state_nxt = EMPTY;
          end else if (code == KEY_ENTER) begin
            if (eff_state == FULL) begin
              // Commit bookkeeping lands on the ENTER edge so that the ready
              // cycle already shows the new count and a cleared buffer.
              num_ld    = 1'b1;
              rdy_nxt   = 1'b1;
              gc_nxt    = (oGuessCnt == GC_MAX) ? oGuessCnt : oGuessCnt + 7'd1;
              e1_nxt    = '0;
              e2_nxt    = '0;
              e3_nxt    = '0;
              cnt_nxt   = 2'd0;
              hold_nxt  = HOLD_LOAD;
              state_nxt = COMMIT;
            end else begin
              err_nxt = 1'b1;
            end
          end
          // 0xD..0xF fall through with no effect.
        end
      end
      COMMIT: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        hold_nxt = hold_cnt - HW'(1);
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase

    busy_nxt = (state_nxt == COMMIT) || (state_nxt == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_cnt  <= '0;
      oEntry1   <= '0;
      oEntry2   <= '0;
      oEntry3   <= '0;
      oCount    <= 2'd0;
      oGuessCnt <= 7'd0;
      oErr      <= 1'b0;
      oNumRdy   <= 1'b0;
      oBusy     <= 1'b0;
      oNum1     <= '0;
      oNum2     <= '0;
      oNum3     <= '0;
    end else begin
      hold_cnt  <= hold_nxt;
      oEntry1   <= e1_nxt;
      oEntry2   <= e2_nxt;
      oEntry3   <= e3_nxt;
      oCount    <= cnt_nxt;
      oGuessCnt <= gc_nxt;
      oErr      <= err_nxt;
      oNumRdy   <= rdy_nxt;
      oBusy     <= busy_nxt;
      if (num_ld) begin
        oNum1 <= oEntry1;
        oNum2 <= oEntry2;
        oNum3 <= oEntry3;
      end
    end
  end

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry: table of single-key vectors for the entry
// buffer, plus hand-written sequences for commit, holdoff, held keys,
// counter saturation and reset during holdoff.
module tb_guess_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] iKeyCode;
  logic       iKeyValid;
  logic [3:0] oNum1, oNum2, oNum3;
  logic       oNumRdy;
  logic [3:0] oEntry1, oEntry2, oEntry3;
  logic [1:0] oCount;
  logic [6:0] oGuessCnt;
  logic       oErr;
  logic       oBusy;

  int checks   = 0;
  int failures = 0;
  int exp_gc   = 0;

  always #5 clk = ~clk;

  guess_entry #(.HOLDOFF(16), .MAX_CNT(99)) dut (
    .clk       (clk),
    .reset     (reset),
    .iKeyCode  (iKeyCode),
    .iKeyValid (iKeyValid),
    .oNum1     (oNum1),
    .oNum2     (oNum2),
    .oNum3     (oNum3),
    .oNumRdy   (oNumRdy),
    .oEntry1   (oEntry1),
    .oEntry2   (oEntry2),
    .oEntry3   (oEntry3),
    .oCount    (oCount),
    .oGuessCnt (oGuessCnt),
    .oErr      (oErr),
    .oBusy     (oBusy)
  );

  typedef struct {
    logic [3:0] code;
    logic [1:0] cnt;
    logic [3:0] e1, e2, e3;
    logic       err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Raise the key before an edge and return just after that edge.
  task automatic press_hi(input logic [3:0] c);
    @(negedge clk);
    iKeyValid = 1'b1;
    iKeyCode  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic release_lo();
    @(negedge clk);
    iKeyValid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic [3:0] c);
    press_hi(c);
    release_lo();
  endtask

  // Full commit; returns after oBusy has dropped.
  task automatic do_commit(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int busy_n, rdy_n;
    tap(a); tap(b); tap(c);
    press_hi(4'hB);
    if (exp_gc < 99) exp_gc++;
    chk("commit_rdy", oNumRdy, 1);
    chk("commit_num", {oNum1, oNum2, oNum3}, {a, b, c});
    chk("commit_gc", oGuessCnt, exp_gc);
    chk("commit_cnt", oCount, 0);
    chk("commit_err", oErr, 0);
    busy_n = oBusy ? 1 : 0;
    rdy_n  = 1;
    for (int i = 0; i < 100 && oBusy; i++) begin
      @(negedge clk);
      iKeyValid = 1'b0;
      @(posedge clk);
      #1;
      if (oBusy) busy_n++;
      if (oNumRdy) rdy_n++;
    end
    chk("busy_len", busy_n, 17);
    chk("rdy_len", rdy_n, 1);
  endtask

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{4'h4, 2'd1, 4'd4, 4'd0, 4'd0, 1'b0};
    vecs[1]  = '{4'h4, 2'd1, 4'd4, 4'd0, 4'd0, 1'b1};
    vecs[2]  = '{4'h5, 2'd2, 4'd4, 4'd5, 4'd0, 1'b0};
    vecs[3]  = '{4'h6, 2'd3, 4'd4, 4'd5, 4'd6, 1'b0};
    vecs[4]  = '{4'h7, 2'd3, 4'd4, 4'd5, 4'd6, 1'b1};
    vecs[5]  = '{4'hA, 2'd2, 4'd4, 4'd5, 4'd0, 1'b0};
    vecs[6]  = '{4'hC, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[7]  = '{4'hC, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[8]  = '{4'h8, 2'd1, 4'd8, 4'd0, 4'd0, 1'b0};
    vecs[9]  = '{4'h9, 2'd2, 4'd8, 4'd9, 4'd0, 1'b0};
    vecs[10] = '{4'hA, 2'd1, 4'd8, 4'd0, 4'd0, 1'b0};
    vecs[11] = '{4'hA, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[12] = '{4'hA, 2'd0, 4'd0, 4'd0, 4'd0, 1'b1};
    vecs[13] = '{4'hB, 2'd0, 4'd0, 4'd0, 4'd0, 1'b1};
    vecs[14] = '{4'hE, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[15] = '{4'h0, 2'd1, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[16] = '{4'h0, 2'd1, 4'd0, 4'd0, 4'd0, 1'b1};
    vecs[17] = '{4'hB, 2'd1, 4'd0, 4'd0, 4'd0, 1'b1};
    vecs[18] = '{4'hC, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0};

    reset     = 1'b0;
    iKeyValid = 1'b0;
    iKeyCode  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {oNum1, oNum2, oNum3, oNumRdy, oEntry1, oEntry2, oEntry3,
                       oCount, oGuessCnt, oErr, oBusy}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Entry buffer vectors.
    foreach (vecs[i]) begin
      press_hi(vecs[i].code);
      chk($sformatf("v%0d_cnt", i), oCount, vecs[i].cnt);
      chk($sformatf("v%0d_ent", i), {oEntry1, oEntry2, oEntry3},
          {vecs[i].e1, vecs[i].e2, vecs[i].e3});
      chk($sformatf("v%0d_err", i), oErr, vecs[i].err);
      chk($sformatf("v%0d_rdy", i), oNumRdy, 0);
      release_lo();
      chk($sformatf("v%0d_err_drop", i), oErr, 0);
    end

    // Basic commit.
    do_commit(4'd1, 4'd2, 4'd3);
    chk("post_commit_cnt", oCount, 0);

    // Key held for 50 cycles: one digit only.
    press_hi(4'h7);
    repeat (49) @(posedge clk);
    #1;
    chk("held_cnt", oCount, 1);
    chk("held_ent", oEntry1, 7);
    release_lo();
    tap(4'hC);

    // Key held across reset release: nothing accepted, counter cleared.
    @(negedge clk);
    iKeyValid = 1'b1;
    iKeyCode  = 4'h7;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_gc = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("held_reset_cnt", oCount, 0);
    chk("held_reset_gc", oGuessCnt, 0);
    release_lo();

    // Press during holdoff is ignored silently; after holdoff it is accepted.
    begin
      int busy_guard;
      tap(4'd4); tap(4'd5); tap(4'd6);
      press_hi(4'hB);
      exp_gc++;
      chk("hold_rdy", oNumRdy, 1);
      repeat (4) release_lo();
      press_hi(4'd3);
      chk("hold_press_err", oErr, 0);
      chk("hold_press_cnt", oCount, 0);
      chk("hold_press_num", {oNum1, oNum2, oNum3}, {4'd4, 4'd5, 4'd6});
      chk("hold_busy", oBusy, 1);
      release_lo();
      busy_guard = 0;
      while (oBusy && busy_guard < 100) begin
        @(posedge clk);
        #1;
        busy_guard++;
      end
      chk("hold_timeout", (busy_guard < 100) ? 1 : 0, 1);
      chk("hold_ent_empty", oEntry1, 0);
      press_hi(4'd3);
      chk("after_hold_cnt", oCount, 1);
      chk("after_hold_ent", oEntry1, 3);
      chk("after_hold_num", {oNum1, oNum2, oNum3}, {4'd4, 4'd5, 4'd6});
      release_lo();
      tap(4'hC);
    end

    // Saturation of the commit counter.
    for (int n = 0; n < 101; n++) begin
      do_commit(4'(n % 10), 4'((n + 1) % 10), 4'((n + 2) % 10));
    end
    chk("gc_saturated", oGuessCnt, 99);

    // Reset asserted during HOLD.
    tap(4'd7); tap(4'd8); tap(4'd9);
    press_hi(4'hB);
    repeat (5) release_lo();
    chk("mid_hold_busy", oBusy, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_hold", {oNum1, oNum2, oNum3, oNumRdy, oEntry1, oEntry2, oEntry3,
                          oCount, oGuessCnt, oErr, oBusy}, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_gc = 0;
    repeat (2) @(posedge clk);
    #1;
    tap(4'd2);
    chk("after_reset_accept", oCount, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a runaway simulation.
  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/guess_entry.md
# guess_entry

Keypad entry stage for the 1A2B guessing game: collects three distinct decimal digits, one per keystroke, then on ENTER presents them as one guess with a single-cycle ready strobe. Sits directly upstream of the game control/display block, whose number inputs and ready input connect to `oNum1..oNum3` and `oNumRdy`. The first guess committed after reset is the secret answer downstream; later commits are guesses. An in-progress entry buffer and a commit counter are exported for on-screen echo.

## Interface
- `HOLDOFF`, 16: cycles after a commit during which all keys are ignored (≥1).
- `MAX_CNT`, 99: saturation value of `oGuessCnt`.

- `clk`  in  1  system clock, sole clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `iKeyCode`  in  4  key code: 0x0–0x9 digit, 0xA BACKSPACE, 0xB ENTER, 0xC CLEAR, 0xD–0xF ignored.
- `iKeyValid`  in  1  level, high while a key is held; `iKeyCode` is stable while high.
- `oNum1`  out  4  first digit of last committed guess.
- `oNum2`  out  4  second digit of last committed guess.
- `oNum3`  out  4  third digit of last committed guess.
- `oNumRdy`  out  1  one-cycle strobe, `oNum1..3` valid.
- `oEntry1`, `oEntry2`, `oEntry3`  out  4 each  in-progress digits; unused slots are 0.
- `oCount`  out  2  digits currently buffered, 0–3.
- `oGuessCnt`  out  7  commits since reset, saturating at `MAX_CNT`.
- `oErr`  out  1  one-cycle strobe on a rejected keystroke.
- `oBusy`  out  1  high in COMMIT and HOLD.

## Operation
- Reset (`reset`=0 at an edge): every output is 0, the state is EMPTY, the holdoff counter is 0, and the previous-key sample is forced to 1. A key held through reset release is not a press.
- Press = `iKeyValid` sampled 1 with the previous sample 0; `iKeyCode` is captured at that edge. A held key produces exactly one press, and code changes while held are ignored.
- States: EMPTY (count 0), PARTIAL (count 1–2), FULL (count 3), COMMIT, HOLD.
- Digit d in EMPTY/PARTIAL:
  - If d is not already buffered, it goes to slot `oCount`+1, count increments, and the state advances to PARTIAL, or to FULL at count 3.
  - If d equals a buffered digit, the buffer is unchanged and `oErr` strobes.
- Digit in FULL: rejected, `oErr` strobes.
- BACKSPACE: the last slot is zeroed and count decrements; the state drops to PARTIAL, or to EMPTY at count 0. In EMPTY it is rejected with `oErr`.
- CLEAR: all slots are zeroed and the state goes to EMPTY, from any entry state. No error, even when already empty.
- ENTER in FULL: buffer copied to `oNum1..3`, state goes to COMMIT. ENTER in EMPTY/PARTIAL is rejected with `oErr`.
- Codes 0xD–0xF: no effect, no error.
- COMMIT lasts one cycle:
  - `oNumRdy`=1.
  - `oGuessCnt` increments unless it equals `MAX_CNT`.
  - Buffer and `oCount` are cleared.
  - The holdoff counter is loaded with `HOLDOFF`-1.
  - Next state is HOLD.
- HOLD decrements the counter each cycle and moves to EMPTY when it reads 0. Presses in COMMIT/HOLD are discarded silently, and edge tracking continues.
- `oNum1..3` hold their value until the next commit.

## Timing
- All outputs are registered.
- A press whose high sample is at edge k updates `oEntry*`/`oCount`/`oErr` on that edge, so they are visible in cycle k..k+1.
- An ENTER press at edge k gives `oNumRdy`=1 and the new `oNum1..3` in cycle k..k+1. `oNum1..3` and `oNumRdy` change on the same edge.
- `oBusy` is high from edge k through the last HOLD cycle, `HOLDOFF`+1 cycles in total. The first accepted press can occur at edge k+`HOLDOFF`+1.
- `oErr` and `oNumRdy` are never high in the same cycle.
- Reset dominates any simultaneous press, COMMIT or HOLD. Reset mid-HOLD goes straight to EMPTY with all outputs 0.
- Minimum press period is 2 cycles (high, low).

## Structure
- Package `game_pkg` holds:
  - key code constants `KEY_BKSP`=0xA, `KEY_ENTER`=0xB, `KEY_CLEAR`=0xC;
  - the entry state enum {EMPTY, PARTIAL, FULL, COMMIT, HOLD};
  - the 4-bit digit type, which the display side also uses.
- Sub-module `key_edge`: previous-sample register (reset to 1), press strobe and captured code. The FSM, buffer, duplicate check (three 4-bit compares), holdoff counter and guess counter live in `guess_entry`.

## Test plan
- Reset, then press 1,2,3 and ENTER: `oNumRdy` for exactly one cycle with `oNum`=1/2/3, `oGuessCnt`=1, `oCount`=0, `oBusy` for 17 cycles.
- Press 4,4: second press gives `oErr`=1 and `oCount` stays 1. Then 5,6,7: third digit gives `oErr`, buffer stays 4/5/6.
- Press 8,9, BACKSPACE, BACKSPACE, BACKSPACE: `oCount` goes 2→1→0, the last press gives `oErr`. ENTER with count 0 gives `oErr`, and `oNumRdy` stays 0.
- Hold `iKeyValid` at code 7 for 50 cycles: one digit accepted. Hold key 7 across a reset release: nothing accepted.
- Commit, then press 3 at 5 cycles after `oNumRdy`: ignored with no `oErr`, `oNum` unchanged. Press again after `oBusy` falls: accepted.
- Commit 101 valid guesses: `oGuessCnt` stops at 99. Assert reset during HOLD: all outputs 0 on the next cycle.
